// File: rtl/br_resolve_unit_if.sv
// ----------------------------------------------------------------------------
// br_resolve_unit_if
//  Bundles the fetch-side push port, the execute-side resolve port and the
//  predictor-update / flush outputs of br_resolve_unit.
//  master : the pipeline side (drives push_* and res_*, observes the rest)
//  slave  : br_resolve_unit itself
//  Signals:
//   push_valid/push_index/push_pred_taken/push_pred_target/push_fallthru
//                                   branch recorded at fetch
//   full/empty                      FIFO occupancy flags
//   res_valid/res_taken/res_target  outcome of the oldest branch from execute
//   upd_valid/upd_index/upd_taken/upd_target
//                                   predictor table update
//   flush/redirect_pc               wrong-path kill and fetch redirect
// ----------------------------------------------------------------------------
interface br_resolve_unit_if #(
   parameter int IDX_W = 3
);
   logic             push_valid;
   logic [IDX_W-1:0] push_index;
   logic             push_pred_taken;
   logic [31:0]      push_pred_target;
   logic [31:0]      push_fallthru;
   logic             full;
   logic             empty;
   logic             res_valid;
   logic             res_taken;
   logic [31:0]      res_target;
   logic             upd_valid;
   logic [IDX_W-1:0] upd_index;
   logic             upd_taken;
   logic [31:0]      upd_target;
   logic             flush;
   logic [31:0]      redirect_pc;

   modport master (
      output push_valid, push_index, push_pred_taken, push_pred_target, push_fallthru,
      output res_valid, res_taken, res_target,
      input  full, empty,
      input  upd_valid, upd_index, upd_taken, upd_target,
      input  flush, redirect_pc
   );

   modport slave (
      input  push_valid, push_index, push_pred_taken, push_pred_target, push_fallthru,
      input  res_valid, res_taken, res_target,
      output full, empty,
      output upd_valid, upd_index, upd_taken, upd_target,
      output flush, redirect_pc
   );
endinterface

// File: rtl/br_resolve_unit.sv
// ----------------------------------------------------------------------------
// br_resolve_unit
//  Resolution-side partner of the branch predictor. Each predicted branch is
//  recorded at fetch in a small in-order FIFO; when execute resolves the
//  oldest branch, the head entry is checked against the real outcome and the
//  predictor update, pipeline flush and fetch redirect are produced one cycle
//  later.
//  Ports:
//   CLK             clock, rising edge
//   nRST            asynchronous reset, active-low
//   bus             br_resolve_unit_if.slave (push, resolve, update, flush)
//   orphan_err      sticky: a resolve arrived while the FIFO was empty
//   mispredict_cnt  saturating count of mispredictions
// ----------------------------------------------------------------------------
module br_resolve_unit #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 3,
   parameter int CNT_W = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   br_resolve_unit_if.slave  bus,
   output logic              orphan_err,
   output logic [CNT_W-1:0]  mispredict_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);

   logic [IDX_W-1:0] fifo_index       [DEPTH];
   logic             fifo_pred_taken  [DEPTH];
   logic [31:0]      fifo_pred_target [DEPTH];
   logic [31:0]      fifo_fallthru    [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   logic             full;
   logic             empty;
   logic             pop;
   logic             push_ok;
   logic             mispredict;

   logic             upd_valid;
   logic [IDX_W-1:0] upd_index;
   logic             upd_taken;
   logic [31:0]      upd_target;
   logic             flush;
   logic [31:0]      redirect_pc;

   assign full  = (count == COUNT_FULL);
   assign empty = (count == '0);

   // A pop always consumes the head. A mispredicted pop throws away every
   // younger entry, so a push in that same cycle is wrong-path and is dropped.
   // Push into a full FIFO is allowed only when the head leaves this cycle.
   always_comb begin
      pop        = bus.res_valid & ~empty;
      mispredict = 1'b0;
      if (pop) begin
         if (bus.res_taken != fifo_pred_taken[rd_ptr])
            mispredict = 1'b1;
         else if (bus.res_taken && (bus.res_target != fifo_pred_target[rd_ptr]))
            mispredict = 1'b1;
      end
      push_ok = bus.push_valid & (~full | pop) & ~mispredict;
   end

   // Entry storage needs no reset: only entries between rd_ptr and wr_ptr
   // are ever read.
   always_ff @(posedge CLK) begin
      if (push_ok) begin
         fifo_index[wr_ptr]       <= bus.push_index;
         fifo_pred_taken[wr_ptr]  <= bus.push_pred_taken;
         fifo_pred_target[wr_ptr] <= bus.push_pred_target;
         fifo_fallthru[wr_ptr]    <= bus.push_fallthru;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (mispredict) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Update, flush and redirect are registered; upd_* and redirect_pc keep
   // their last value between events.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         upd_valid      <= 1'b0;
         upd_index      <= '0;
         upd_taken      <= 1'b0;
         upd_target     <= '0;
         flush          <= 1'b0;
         redirect_pc    <= '0;
         orphan_err     <= 1'b0;
         mispredict_cnt <= '0;
      end else begin
         upd_valid <= pop;
         flush     <= mispredict;
         if (pop) begin
            upd_index  <= fifo_index[rd_ptr];
            upd_taken  <= bus.res_taken;
            upd_target <= bus.res_target;
         end
         if (mispredict) begin
            redirect_pc <= bus.res_taken ? bus.res_target : fifo_fallthru[rd_ptr];
            if (mispredict_cnt != '1)
               mispredict_cnt <= mispredict_cnt + 1'b1;
         end
         if (bus.res_valid && empty)
            orphan_err <= 1'b1;
      end
   end

   assign bus.full        = full;
   assign bus.empty       = empty;
   assign bus.upd_valid   = upd_valid;
   assign bus.upd_index   = upd_index;
   assign bus.upd_taken   = upd_taken;
   assign bus.upd_target  = upd_target;
   assign bus.flush       = flush;
   assign bus.redirect_pc = redirect_pc;

endmodule

// File: tb/tb_br_resolve_unit.sv
// ----------------------------------------------------------------------------
// tb_br_resolve_unit
//  Self-checking bench for br_resolve_unit. A queue-based reference model
//  tracks the in-flight branches; directed scenarios are followed by a
//  randomized phase. CNT_W is reduced so counter saturation is reachable.
// ----------------------------------------------------------------------------
module tb_br_resolve_unit;

   localparam int DEPTH = 4;
   localparam int IDX_W = 3;
   localparam int CNT_W = 6;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct {
      logic [IDX_W-1:0] idx;
      logic             pt;
      logic [31:0]      ptgt;
      logic [31:0]      ft;
   } entry_t;

   logic             CLK;
   logic             nRST;
   logic             orphan_err;
   logic [CNT_W-1:0] mispredict_cnt;

   br_resolve_unit_if #(.IDX_W(IDX_W)) bus ();

   br_resolve_unit #(
      .DEPTH(DEPTH),
      .IDX_W(IDX_W),
      .CNT_W(CNT_W)
   ) dut (
      .CLK(CLK),
      .nRST(nRST),
      .bus(bus),
      .orphan_err(orphan_err),
      .mispredict_cnt(mispredict_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int assert_count = 0;
   int fail_count   = 0;

   // reference model state
   entry_t           q[$];
   logic             m_upd_valid;
   logic [IDX_W-1:0] m_upd_index;
   logic             m_upd_taken;
   logic [31:0]      m_upd_target;
   logic             m_flush;
   logic [31:0]      m_redirect;
   logic             m_orphan;
   logic [CNT_W-1:0] m_cnt;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      q.delete();
      m_upd_valid  = 1'b0;
      m_upd_index  = '0;
      m_upd_taken  = 1'b0;
      m_upd_target = '0;
      m_flush      = 1'b0;
      m_redirect   = '0;
      m_orphan     = 1'b0;
      m_cnt        = '0;
   endtask

   task automatic checkRegs(input string tag);
      checkOutput({tag, "_upd_valid"},  bus.upd_valid,   m_upd_valid);
      checkOutput({tag, "_upd_index"},  bus.upd_index,   m_upd_index);
      checkOutput({tag, "_upd_taken"},  bus.upd_taken,   m_upd_taken);
      checkOutput({tag, "_upd_target"}, bus.upd_target,  m_upd_target);
      checkOutput({tag, "_flush"},      bus.flush,       m_flush);
      checkOutput({tag, "_redirect"},   bus.redirect_pc, m_redirect);
      checkOutput({tag, "_orphan"},     orphan_err,      m_orphan);
      checkOutput({tag, "_cnt"},        mispredict_cnt,  m_cnt);
   endtask

   task automatic doReset();
      @(negedge CLK);
      nRST = 1'b0;
      bus.push_valid = 1'b0;
      bus.res_valid  = 1'b0;
      modelReset();
      @(negedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      #1;
      checkOutput("rst_empty", bus.empty, 1'b1);
      checkOutput("rst_full",  bus.full,  1'b0);
      checkRegs("rst");
   endtask

   // One clock of stimulus: drive at the falling edge, check occupancy flags,
   // advance the model, then check the registered outputs after the edge.
   task automatic applyStimulus(input logic pv, input logic [IDX_W-1:0] pidx,
                                input logic ppt, input logic [31:0] pptgt,
                                input logic [31:0] pft, input logic rv,
                                input logic rt, input logic [31:0] rtgt);
      entry_t head, ne;
      logic   do_pop, wrong, accept;
      @(negedge CLK);
      bus.push_valid       = pv;
      bus.push_index       = pidx;
      bus.push_pred_taken  = ppt;
      bus.push_pred_target = pptgt;
      bus.push_fallthru    = pft;
      bus.res_valid        = rv;
      bus.res_taken        = rt;
      bus.res_target       = rtgt;
      #1;
      checkOutput("empty", bus.empty, q.size() == 0);
      checkOutput("full",  bus.full,  q.size() == DEPTH);

      do_pop = rv && (q.size() != 0);
      wrong  = 1'b0;
      head   = '{idx: '0, pt: 1'b0, ptgt: '0, ft: '0};
      if (do_pop) begin
         head  = q[0];
         wrong = (rt != head.pt) || (rt && rtgt != head.ptgt);
      end
      if (rv && q.size() == 0)
         m_orphan = 1'b1;
      accept = pv && !wrong && (q.size() < DEPTH || do_pop);

      m_upd_valid = do_pop;
      if (do_pop) begin
         m_upd_index  = head.idx;
         m_upd_taken  = rt;
         m_upd_target = rtgt;
      end
      m_flush = wrong;
      if (wrong) begin
         m_redirect = rt ? rtgt : head.ft;
         if (m_cnt != CNT_MAX)
            m_cnt = m_cnt + 1'b1;
         q.delete();
      end else begin
         if (do_pop)
            void'(q.pop_front());
         if (accept) begin
            ne = '{idx: pidx, pt: ppt, ptgt: pptgt, ft: pft};
            q.push_back(ne);
         end
      end

      @(posedge CLK);
      #1;
      checkRegs("cyc");
      bus.push_valid = 1'b0;
      bus.res_valid  = 1'b0;
   endtask

   task automatic pushBranch(input logic [IDX_W-1:0] idx, input logic pt,
                             input logic [31:0] ptgt, input logic [31:0] ft);
      applyStimulus(1'b1, idx, pt, ptgt, ft, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic resolveBranch(input logic rt, input logic [31:0] rtgt);
      applyStimulus(1'b0, '0, 1'b0, 32'h0, 32'h0, 1'b1, rt, rtgt);
   endtask

   initial begin
      entry_t h;
      logic   rt;
      logic [31:0] tgt;

      nRST = 1'b0;
      bus.push_valid = 1'b0;
      bus.push_index = '0;
      bus.push_pred_taken = 1'b0;
      bus.push_pred_target = '0;
      bus.push_fallthru = '0;
      bus.res_valid = 1'b0;
      bus.res_taken = 1'b0;
      bus.res_target = '0;
      modelReset();

      // reset state
      doReset();

      // predicted not-taken, actually taken
      pushBranch(3'd3, 1'b0, 32'h0, 32'h104);
      resolveBranch(1'b1, 32'h200);
      checkOutput("t2_upd_valid",  bus.upd_valid,   1'b1);
      checkOutput("t2_upd_index",  bus.upd_index,   3'd3);
      checkOutput("t2_upd_target", bus.upd_target,  32'h200);
      checkOutput("t2_flush",      bus.flush,       1'b1);
      checkOutput("t2_redirect",   bus.redirect_pc, 32'h200);
      checkOutput("t2_cnt",        mispredict_cnt,  1);

      // fill, overflow push dropped, drain with correct resolves
      for (int i = 0; i < 5; i++)
         pushBranch(3'(i), 1'b0, 32'h0, 32'h1000 + 32'(4*i));
      checkOutput("t3_full", bus.full, 1'b1);
      for (int i = 0; i < 4; i++) begin
         resolveBranch(1'b0, 32'h0);
         checkOutput("t3_upd_index", bus.upd_index, 3'(i));
         checkOutput("t3_no_flush", bus.flush, 1'b0);
      end
      checkOutput("t3_empty", bus.empty, 1'b1);

      // wrong target on a taken branch kills the younger one
      pushBranch(3'd5, 1'b1, 32'h300, 32'h2004);
      pushBranch(3'd6, 1'b0, 32'h0,   32'h2104);
      resolveBranch(1'b1, 32'h304);
      checkOutput("t4_flush",    bus.flush,       1'b1);
      checkOutput("t4_redirect", bus.redirect_pc, 32'h304);
      checkOutput("t4_empty",    bus.empty,       1'b1);
      resolveBranch(1'b0, 32'h0);
      checkOutput("t4_no_upd_b", bus.upd_valid, 1'b0);

      // simultaneous pop and push while full
      for (int i = 0; i < 4; i++)
         pushBranch(3'(i), 1'b0, 32'h0, 32'h3000 + 32'(4*i));
      applyStimulus(1'b1, 3'd7, 1'b0, 32'h0, 32'h3100, 1'b1, 1'b0, 32'h0);
      checkOutput("t5_full", bus.full, 1'b1);
      for (int i = 0; i < 4; i++)
         resolveBranch(1'b0, 32'h0);
      checkOutput("t5_last_idx", bus.upd_index, 3'd7);
      checkOutput("t5_empty",    bus.empty,     1'b1);

      // counter saturation, then orphan resolve
      doReset();
      for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
         pushBranch(3'(i), 1'b0, 32'h0, 32'h4000);
         resolveBranch(1'b1, 32'h4400);
      end
      checkOutput("t6_cnt_sat", mispredict_cnt, CNT_MAX);
      resolveBranch(1'b1, 32'h0);
      checkOutput("t6_orphan", orphan_err,    1'b1);
      checkOutput("t6_no_upd", bus.upd_valid, 1'b0);
      resolveBranch(1'b0, 32'h0);
      checkOutput("t6_orphan_sticky", orphan_err, 1'b1);

      // randomized traffic
      doReset();
      for (int i = 0; i < 600; i++) begin
         rt  = 1'($urandom_range(0, 1));
         tgt = 32'h5000 + 32'($urandom_range(0, 3) * 4);
         if (q.size() != 0 && $urandom_range(0, 3) != 0) begin
            h = q[0];
            tgt = ($urandom_range(0, 3) != 0) ? h.ptgt : tgt;
            rt  = ($urandom_range(0, 3) != 0) ? h.pt : rt;
         end
         applyStimulus(1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom),
                       32'h5000 + 32'($urandom_range(0, 3) * 4),
                       32'h6000 + 32'($urandom_range(0, 255) * 4),
                       ($urandom_range(0, 2) != 0), rt, tgt);
      end

      // asynchronous reset in the middle of activity
      pushBranch(3'd1, 1'b1, 32'h700, 32'h7004);
      pushBranch(3'd2, 1'b0, 32'h0,   32'h7104);
      resolveBranch(1'b0, 32'h0);
      @(negedge CLK);
      #2;
      nRST = 1'b0;
      modelReset();
      #1;
      checkOutput("async_empty", bus.empty,      1'b1);
      checkOutput("async_flush", bus.flush,      1'b0);
      checkOutput("async_upd",   bus.upd_valid,  1'b0);
      checkOutput("async_cnt",   mispredict_cnt, 0);
      @(negedge CLK);
      nRST = 1'b1;
      resolveBranch(1'b0, 32'h0);
      checkOutput("async_orphan_after", orphan_err, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assert_count, fail_count);
      $finish;
   end

endmodule
